// File: rtl/astro_cart_pkg.sv
// Shared types and helpers for the cartridge loader: state encoding, window size, bank rounding.
package astro_cart_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} cart_state_t;

    localparam int CART_MAX_BYTES = 8192;
    localparam int CART_ADDR_W    = 13;

    // Smallest power-of-two bank (>= 2**min_log2, <= window) holding size bytes, returned as bank-1.
    function automatic logic [CART_ADDR_W-1:0] bank_mask(input logic [CART_ADDR_W:0] size,
                                                         input int min_log2);
        logic [CART_ADDR_W:0] bank;
        bank = 14'(1) << min_log2;
        for (int i = 0; i < CART_ADDR_W; i++) begin
            if (bank < size && bank < 14'(CART_MAX_BYTES))
                bank = bank << 1;
        end
        return CART_ADDR_W'(bank - 14'd1);
    endfunction

endpackage

// File: rtl/astro_cart_loader_if.sv
// Loader bus: HPS ioctl stream and core cart address in, dpram port A and load status out.
// Optional cart_sum output present when CART_LOADER_CHECKSUM_EN is defined.
interface astro_cart_loader_if;
    import astro_cart_pkg::*;

    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic [CART_ADDR_W-1:0] cpu_addr;
    logic [CART_ADDR_W-1:0] ram_addr;
    logic [7:0]             ram_din;
    logic                   ram_we;
    logic [CART_ADDR_W:0]   cart_size;
    logic                   cart_valid;
    logic                   cart_overflow;
    logic                   busy;
`ifdef CART_LOADER_CHECKSUM_EN
    logic [7:0]             cart_sum;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_addr,
        input  ram_addr, ram_din, ram_we, cart_size, cart_valid, cart_overflow, busy, cart_sum
    );
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_addr,
        output ram_addr, ram_din, ram_we, cart_size, cart_valid, cart_overflow, busy, cart_sum
    );
`else
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_addr,
        input  ram_addr, ram_din, ram_we, cart_size, cart_valid, cart_overflow, busy
    );
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_addr,
        output ram_addr, ram_din, ram_we, cart_size, cart_valid, cart_overflow, busy
    );
`endif

endinterface

// File: rtl/astro_cart_size_round.sv
// Combinational mapping of a loaded byte count to its bank size R and address mask R-1.
module astro_cart_size_round
    import astro_cart_pkg::*;
#(
    parameter int MIN_BANK_LOG2 = 11
) (
    input  logic [CART_ADDR_W:0]   i_size,
    output logic [CART_ADDR_W:0]   o_bank_bytes,
    output logic [CART_ADDR_W-1:0] o_bank_mask
);

    always_comb begin
        o_bank_mask  = bank_mask(i_size, MIN_BANK_LOG2);
        o_bank_bytes = {1'b0, o_bank_mask} + 14'd1;
    end

endmodule

// File: rtl/astro_cart_loader.sv
// Cartridge loader: captures the ioctl cart stream into dpram, pads to a power-of-two bank, then mirrors cpu_addr.
// Optional macro CART_LOADER_CHECKSUM_EN adds an 8-bit running sum of every byte written.
module astro_cart_loader
    import astro_cart_pkg::*;
#(
    parameter logic [7:0] CART_INDEX    = 8'd1,
    parameter logic [7:0] FILL_BYTE     = 8'hFF,
    parameter int         MIN_BANK_LOG2 = 11
) (
    input  logic              clk_sys,
    input  logic              reset,
    astro_cart_loader_if.slave bus
);

    cart_state_t            r_state, w_state_next;
    logic                   r_dl_prev, r_we, r_overflow;
    logic [CART_ADDR_W-1:0] r_wr_addr, r_mask, w_bank_mask;
    logic [7:0]             r_wr_data;
    logic [CART_ADDR_W:0]   r_size, r_ptr, w_size_next, w_bank_bytes, w_addr_p1;
    logic                   w_cart, w_rise, w_fall, w_wr_in, w_wr_over, w_fill_we;

    assign w_cart    = (bus.ioctl_index == CART_INDEX);
    assign w_rise    = bus.ioctl_download & ~r_dl_prev & w_cart;
    assign w_fall    = ~bus.ioctl_download & r_dl_prev & w_cart;
    assign w_wr_in   = (r_state == LOAD) & bus.ioctl_wr & w_cart
                       & (bus.ioctl_addr < 25'(CART_MAX_BYTES));
    assign w_wr_over = (r_state == LOAD) & bus.ioctl_wr & w_cart
                       & (bus.ioctl_addr >= 25'(CART_MAX_BYTES));
    assign w_addr_p1 = {1'b0, bus.ioctl_addr[CART_ADDR_W-1:0]} + 14'd1;
    // A write pending from the final LOAD cycle takes the port first; fill waits one cycle.
    assign w_fill_we = (r_state == FILL) & ~r_we & (r_ptr < w_bank_bytes);

    always_comb begin
        w_size_next = r_size;
        if (w_wr_in && (w_addr_p1 > r_size))
            w_size_next = w_addr_p1;
    end

    astro_cart_size_round #(.MIN_BANK_LOG2(MIN_BANK_LOG2)) u_size_round (
        .i_size      (w_size_next),
        .o_bank_bytes(w_bank_bytes),
        .o_bank_mask (w_bank_mask)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_rise) w_state_next = LOAD;
            LOAD: if (w_fall) w_state_next = (w_size_next == '0) ? IDLE : FILL;
            FILL: begin
                if (w_rise)                             w_state_next = LOAD;
                else if (!r_we && r_ptr >= w_bank_bytes) w_state_next = DONE;
            end
            DONE: if (w_rise) w_state_next = LOAD;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_prev  <= 1'b0;
            r_we       <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_size     <= '0;
            r_overflow <= 1'b0;
            r_ptr      <= '0;
            r_mask     <= '1;
        end else begin
            r_dl_prev <= bus.ioctl_download;
            r_we      <= w_wr_in;
            r_size    <= w_size_next;
            if (w_wr_in) begin
                r_wr_addr <= bus.ioctl_addr[CART_ADDR_W-1:0];
                r_wr_data <= bus.ioctl_dout;
            end
            if (w_wr_over)
                r_overflow <= 1'b1;
            if (r_state == LOAD && w_fall && w_size_next != '0) begin
                r_mask <= w_bank_mask;
                r_ptr  <= w_size_next;
            end
            if (w_fill_we)
                r_ptr <= r_ptr + 14'd1;
            if (w_rise && r_state != LOAD) begin
                r_size     <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef CART_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk_sys) begin
        if (reset)                          r_sum <= '0;
        else if (w_rise && r_state != LOAD) r_sum <= '0;
        else if (w_wr_in)                   r_sum <= r_sum + bus.ioctl_dout;
        else if (w_fill_we)                 r_sum <= r_sum + FILL_BYTE;
    end

    assign bus.cart_sum = r_sum;
`endif

    always_comb begin
        bus.ram_we        = r_we | w_fill_we;
        bus.ram_din       = w_fill_we ? FILL_BYTE : r_wr_data;
        bus.cart_size     = r_size;
        bus.cart_valid    = (r_state == DONE);
        bus.cart_overflow = r_overflow;
        bus.busy          = (r_state == LOAD) || (r_state == FILL);
        if (r_we || r_state == LOAD) bus.ram_addr = r_wr_addr;
        else if (r_state == FILL)    bus.ram_addr = r_ptr[CART_ADDR_W-1:0];
        else                         bus.ram_addr = bus.cpu_addr & r_mask;
    end

endmodule

// File: tb/tb_astro_cart_loader.sv
// Directed bench for astro_cart_loader; every dpram write is matched against a scoreboard queue.
module tb_astro_cart_loader;

    logic clk_sys;
    logic reset;
    int   checks;
    int   errors;
    int   n_wr;
    logic [20:0] sb[$];

    astro_cart_loader_if bus ();

    astro_cart_loader dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write on the dpram port must be the next expected {addr, data}.
    always @(negedge clk_sys) begin
        if (bus.ram_we === 1'b1) begin
            logic [20:0] exp_w;
            n_wr++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%0h expected=none", {bus.ram_addr, bus.ram_din});
            end
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                chk("ram_write", 32'({bus.ram_addr, bus.ram_din}), 32'(exp_w));
            end
        end
    end

    function automatic int bank_of(input int sz);
        if (sz <= 2048) return 2048;
        if (sz <= 4096) return 4096;
        return 8192;
    endfunction

    // Drives a cart download of n bytes (data = addr[7:0]); the last write shares its cycle with the fall.
    task automatic start_load(input int n);
        int sz;
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        @(posedge clk_sys) #1;
        chk("busy_in_load", 32'(bus.busy), 32'd1);
        for (int a = 0; a < n; a++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(a);
            bus.ioctl_dout = 8'(a);
            if (a < 8192) sb.push_back({13'(a), 8'(a)});
            if (a == n - 1) bus.ioctl_download = 1'b0;
            @(posedge clk_sys) #1;
        end
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        sz = (n > 8192) ? 8192 : n;
        if (sz > 0)
            for (int p = sz; p < bank_of(sz); p++) sb.push_back({13'(p), 8'hFF});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_sys);
            if (bus.busy === 1'b0) break;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int wr0;
        bit hit;
        checks = 0;
        errors = 0;
        n_wr   = 0;
        reset  = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd1;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.cpu_addr       = 13'h1234;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_ram_we",    32'(bus.ram_we),        32'd0);
        chk("rst_ram_din",   32'(bus.ram_din),       32'd0);
        chk("rst_cart_size", 32'(bus.cart_size),     32'd0);
        chk("rst_valid",     32'(bus.cart_valid),    32'd0);
        chk("rst_overflow",  32'(bus.cart_overflow), 32'd0);
        chk("rst_busy",      32'(bus.busy),          32'd0);
        chk("rst_mirror",    32'(bus.ram_addr),      32'h1234);
        reset = 1'b0;
        @(posedge clk_sys) #1;

        // exact 2 KB image: no padding
        wr0 = n_wr;
        start_load(2048);
        wait_idle();
        chk("2k_writes", 32'(n_wr - wr0), 32'd2048);
        chk("2k_size",   32'(bus.cart_size), 32'd2048);
        chk("2k_valid",  32'(bus.cart_valid), 32'd1);
        bus.cpu_addr = 13'h0805;
        #1 chk("2k_mirror", 32'(bus.ram_addr), 32'h0005);

        // 3000 bytes from DONE: padded to 4 KB
        wr0 = n_wr;
        start_load(3000);
        wait_idle();
        chk("3k_writes",   32'(n_wr - wr0), 32'd4096);
        chk("3k_size",     32'(bus.cart_size), 32'd3000);
        chk("3k_valid",    32'(bus.cart_valid), 32'd1);
        chk("3k_overflow", 32'(bus.cart_overflow), 32'd0);
        bus.cpu_addr = 13'h1BB8;
        #1 chk("3k_mirror", 32'(bus.ram_addr), 32'h0BB8);

        // foreign-index download while DONE is ignored
        wr0 = n_wr;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        @(posedge clk_sys) #1;
        for (int a = 0; a < 100; a++) begin
            bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(a);
            @(posedge clk_sys) #1;
        end
        bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        bus.ioctl_index = 8'd1;
        chk("idx0_writes", 32'(n_wr - wr0), 32'd0);
        chk("idx0_valid",  32'(bus.cart_valid), 32'd1);
        chk("idx0_size",   32'(bus.cart_size), 32'd3000);
        chk("idx0_busy",   32'(bus.busy), 32'd0);

        // oversize download: clipped at 8 KB, overflow flagged
        wr0 = n_wr;
        start_load(8200);
        wait_idle();
        chk("8k_writes",   32'(n_wr - wr0), 32'd8192);
        chk("8k_size",     32'(bus.cart_size), 32'd8192);
        chk("8k_overflow", 32'(bus.cart_overflow), 32'd1);
        chk("8k_valid",    32'(bus.cart_valid), 32'd1);
        bus.cpu_addr = 13'h1ABC;
        #1 chk("8k_mirror", 32'(bus.ram_addr), 32'h1ABC);

        // reset while filling at pointer 3500
        start_load(3000);
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_sys);
            if (bus.ram_we === 1'b1 && bus.ram_addr === 13'd3500) begin
                hit = 1'b1;
                break;
            end
        end
        chk("fill_reached_3500", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rstfill_we",    32'(bus.ram_we),     32'd0);
        chk("rstfill_valid", 32'(bus.cart_valid), 32'd0);
        chk("rstfill_busy",  32'(bus.busy),       32'd0);
        chk("rstfill_size",  32'(bus.cart_size),  32'd0);
        sb.delete();
        reset = 1'b0;
        @(posedge clk_sys) #1;

        // empty download
        wr0 = n_wr;
        start_load(0);
        wait_idle();
        repeat (2) @(negedge clk_sys);
        chk("empty_writes", 32'(n_wr - wr0), 32'd0);
        chk("empty_valid",  32'(bus.cart_valid), 32'd0);
        chk("empty_size",   32'(bus.cart_size), 32'd0);
        chk("empty_busy",   32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/astro_cart_loader.md
Name: astro_cart_loader

Overview:
- Sits between the HPS ioctl download stream and the 8 KB cartridge dpram. The BALLY core reads cartridge data from that dpram.
- During a cart download it registers the write stream into the dpram and records the loaded size.
- After the download it pads the image with a fill byte up to the next power-of-two bank size: 2 KB, 4 KB or 8 KB.
- At run time it mirrors the CPU cartridge address into that bank, so short carts alias correctly across the 8 KB window.

Parameters:
- CART_INDEX, 8'd1, ioctl_index value that selects a cartridge download.
- FILL_BYTE, 8'hFF, value written into padding locations.
- MIN_BANK_LOG2, 11, log2 of the smallest bank (2 KB).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download file index.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address of the download.
- ioctl_dout  in  8  download data.
- cpu_addr  in  13  cartridge address from the core (O_CAS_ADDR).
- ram_addr  out  13  dpram address_a.
- ram_din  out  8  dpram data_a.
- ram_we  out  1  dpram wren_a.
- cart_size  out  14  bytes loaded, 0..8192.
- cart_valid  out  1  a non-empty image is loaded and padded.
- cart_overflow  out  1  the download went past 8 KB.
- busy  out  1  load or fill in progress; the top level ORs this into the core reset.

Behaviour:
- Reset values: state IDLE; ram_we=0; ram_din=0; cart_size=0; cart_valid=0; cart_overflow=0; busy=0; fill pointer=0; mask=13'h1FFF.
- State IDLE:
  - Entered at reset. cart_valid=0.
  - A rising edge of ioctl_download with ioctl_index==CART_INDEX goes to LOAD. On that edge: clear cart_size, clear cart_overflow, clear cart_valid.
  - Downloads with any other index are ignored, in every state. State and outputs stay unchanged.
- State LOAD (busy=1):
  - Each ioctl_wr with ioctl_addr<8192 registers {addr[12:0], dout}. The next cycle asserts ram_we for exactly 1 cycle, so write latency is 1 clock.
  - Each such write sets cart_size = max(cart_size, addr+1), using 14-bit arithmetic.
  - ioctl_wr with addr>=8192 sets cart_overflow=1 and produces no write.
  - On the falling edge of ioctl_download:
    - cart_size==0 goes to IDLE with cart_valid=0.
    - Otherwise compute R = smallest of 2048/4096/8192 that is >=cart_size; set mask=R-1; load fill pointer=cart_size; go to FILL.
- State FILL (busy=1):
  - Each cycle with pointer<R: ram_addr=pointer, ram_din=FILL_BYTE, ram_we=1, then pointer increments. This is one byte per clock.
  - When pointer==R go to DONE. Sizes that are exactly 2048, 4096 or 8192 pass through FILL in 1 cycle with no write.
- State DONE (busy=0, cart_valid=1):
  - ram_addr = cpu_addr & mask, combinational, so the read latency is that of the dpram alone.
  - ram_we=0.
- ram_addr mux by state: LOAD uses the registered ioctl address; FILL uses the pointer; DONE and IDLE use cpu_addr & mask. The 13-bit mask keeps addresses inside the window.
- A new cart download rising edge during FILL or DONE aborts immediately and goes to LOAD with the same clears as from IDLE.
- Synchronous reset in any state returns to IDLE on the next edge. Any in-flight write is dropped (ram_we=0).
- ioctl_wr arriving in the same cycle as the falling edge of ioctl_download is still written; the state transition takes effect after that write is captured.

Optional Feature:
- CART_LOADER_CHECKSUM_EN: adds output cart_sum (8 bits).
  - Cleared on entry to LOAD.
  - Adds ioctl_dout (mod 256) for every accepted in-range write.
  - Adds FILL_BYTE for every fill write.
  - Valid when cart_valid=1.
- Without the macro the port and its logic are absent.

Decomposition:
- Package astro_cart_pkg:
  - typedef cart_state_t {IDLE, LOAD, FILL, DONE}.
  - CART_MAX_BYTES=8192; CART_ADDR_W=13.
  - Function bank_mask(size) returning the rounded mask.
- One sub-module, astro_cart_size_round: combinational size→{R, mask} mapping, unit-testable alone.

Test Plan:
- Load 2048 bytes (data = addr[7:0]) with index 1 → no FILL writes; cart_size=2048; cart_valid=1; cpu_addr 13'h0805 reads ram_addr 13'h0005.
- Load 3000 bytes → 1096 fill writes at 3000..4095 with 8'hFF; mask=13'h0FFF; cpu_addr 13'h1BB8 maps to 13'h0BB8.
- Load 8200 bytes → cart_overflow=1; cart_size=8192; no write with addr>=8192; mask=13'h1FFF.
- Download with index 0 of 100 bytes while DONE → ram_we never asserted; cart_valid stays 1; cart_size unchanged.
- Assert reset during FILL at pointer 3500 → next cycle IDLE, ram_we=0, cart_valid=0, busy=0.
- Empty download (rise then fall with no writes) → IDLE, cart_valid=0, cart_size=0, zero writes.
